// File: rtl/mult_hilo_ctrl_pkg.sv
// mult_pkg: shared opcodes, FSM states and default timing constants for the HI/LO multiply controller.
package mult_pkg;
    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        MTHI  = 3'd3,
        MTLO  = 3'd4,
        MFHI  = 3'd5,
        MFLO  = 3'd6
    } op_t;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIX} state_t;
    localparam int MIN_LAT_DEF = 2;
    localparam int TIMEOUT_DEF = 40;
endpackage

// File: rtl/mult_hilo_ctrl_sign_mag32.sv
// sign_mag32: two's-complement magnitude and sign of a 32-bit value; 0x80000000 maps to itself.
module sign_mag32 (
    input  logic [31:0] val_i,
    output logic [31:0] mag_o,
    output logic        sign_o
);
    assign sign_o = val_i[31];
    assign mag_o  = val_i[31] ? ~val_i + 32'd1 : val_i;
endmodule

// File: rtl/mult_hilo_ctrl.sv
// mult_hilo_ctrl: sequences signed/unsigned multiplies through an iterative unsigned multiplier
// into HI/LO, serves HI/LO moves, and stalls the CPU while a multiply is in flight.
module mult_hilo_ctrl
    import mult_pkg::*;
#(
    parameter int MIN_LAT = MIN_LAT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        stall,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        err,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_valid_in,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_valid_out,
    input  logic [63:0] mul_r
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t      state_q;
    logic        neg_q, mul_vin_q, err_q;
    logic [31:0] hi_q, lo_q, mul_a_q, mul_b_q;
    logic [63:0] prod_q, fix_d;
    logic [CW-1:0] cnt_q;
    logic [31:0] mag_a, mag_b;
    logic        sgn_a, sgn_b, idle_req, accept;

    sign_mag32 u_abs_a (.val_i(rs_data), .mag_o(mag_a), .sign_o(sgn_a));
    sign_mag32 u_abs_b (.val_i(rt_data), .mag_o(mag_b), .sign_o(sgn_b));

    assign busy     = state_q != IDLE;
    assign idle_req = op_valid && !busy;
    assign stall    = op_valid && busy;
    assign rd_valid = idle_req && (op == MFHI || op == MFLO);
    assign rd_data  = rd_valid ? (op == MFHI ? hi_q : lo_q) : 32'd0;
    // Early valid_out is a leftover from the previous operation and must be ignored.
    assign accept   = mul_valid_out && cnt_q >= CW'(MIN_LAT);
    assign fix_d    = neg_q ? ~prod_q + 64'd1 : prod_q;

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign err          = err_q;
    assign mul_valid_in = mul_vin_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            mul_vin_q <= 1'b0;
            err_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            mul_a_q   <= 32'd0;
            mul_b_q   <= 32'd0;
            prod_q    <= 64'd0;
            cnt_q     <= '0;
        end else begin
            mul_vin_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (idle_req && op == MULT) begin
                        neg_q     <= sgn_a ^ sgn_b;
                        mul_a_q   <= mag_a;
                        mul_b_q   <= mag_b;
                        mul_vin_q <= 1'b1;
                        state_q   <= LAUNCH;
                    end else if (idle_req && op == MULTU) begin
                        neg_q     <= 1'b0;
                        mul_a_q   <= rs_data;
                        mul_b_q   <= rt_data;
                        mul_vin_q <= 1'b1;
                        state_q   <= LAUNCH;
                    end else if (idle_req && op == MTHI) begin
                        hi_q <= rs_data;
                    end else if (idle_req && op == MTLO) begin
                        lo_q <= rs_data;
                    end
                end
                LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (accept) begin
                        prod_q  <= mul_r;
                        state_q <= FIX;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    {hi_q, lo_q} <= fix_d;
                    state_q      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// tb_mult_hilo_ctrl: directed scenarios for the HI/LO multiply controller with a scripted multiplier.
module tb_mult_hilo_ctrl;
    import mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset, op_valid, mul_valid_out;
    logic [2:0]  op;
    logic [31:0] rs_data, rt_data;
    logic [63:0] mul_r;
    logic        stall, rd_valid, busy, err, mul_valid_in;
    logic [31:0] rd_data, hi, lo, mul_a, mul_b;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_hilo_ctrl dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .err(err),
        .hi(hi), .lo(lo), .mul_valid_in(mul_valid_in), .mul_a(mul_a),
        .mul_b(mul_b), .mul_valid_out(mul_valid_out), .mul_r(mul_r)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        step();
        op_valid = 1'b0;
        op       = NONE;
    endtask

    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op = NONE; rs_data = 0; rt_data = 0;
        mul_valid_out = 1'b0; mul_r = 0;
        step(); step();
        reset = 1'b0;
        #1;
        checks++;
        if ({hi, lo} !== 64'd0) begin failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
        checks++;
        if ({busy, stall, rd_valid, err, mul_valid_in} !== 5'd0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {busy, stall, rd_valid, err, mul_valid_in});
        end
        checks++;
        if ({mul_a, mul_b} !== 64'd0) begin failures++; $display("FAIL reset_operands got=%h exp=0", {mul_a, mul_b}); end
    endtask

    // Launch a multiply, answer after `delay` cycles counted from the launch cycle, then check HI/LO.
    task automatic run_mult(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int delay, input logic [63:0] r,
                            input logic [31:0] ea, input logic [31:0] eb,
                            input logic [31:0] ehi, input logic [31:0] elo);
        int pulses;
        issue(o, a, b);
        pulses = mul_valid_in ? 1 : 0;
        checks++;
        if (mul_a !== ea || mul_b !== eb) begin
            failures++; $display("FAIL %s_operands got=%h/%h exp=%h/%h", name, mul_a, mul_b, ea, eb);
        end
        for (int i = 1; i < delay; i++) begin
            step();
            if (mul_valid_in) pulses++;
        end
        mul_valid_out = 1'b1; mul_r = r;
        step();
        mul_valid_out = 1'b0; mul_r = 64'd0;
        step();
        checks++;
        if (hi !== ehi || lo !== elo) begin
            failures++; $display("FAIL %s_hilo got=%h_%h exp=%h_%h", name, hi, lo, ehi, elo);
        end
        checks++;
        if (pulses !== 1 || busy !== 1'b0) begin
            failures++; $display("FAIL %s_pulse_busy got=%0d/%b exp=1/0", name, pulses, busy);
        end
    endtask

    task automatic test_mult_signed();
        run_mult("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 33, 64'd21, 32'd3, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    endtask

    task automatic test_boundaries();
        run_mult("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 6, 64'hFFFFFFFE_00000001,
                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_mult("mult_min", MULT, 32'h80000000, 32'h80000000, 5, 64'h40000000_00000000,
                 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    endtask

    task automatic test_hazard();
        int bad;
        bad = 0;
        issue(MULT, 32'hFFFFFFFE, 32'd3);
        op_valid = 1'b1; op = MFHI;
        #1;
        for (int i = 1; i < 4; i++) begin
            if (stall !== 1'b1 || rd_valid !== 1'b0) bad++;
            step();
        end
        mul_valid_out = 1'b1; mul_r = 64'd6;
        step();
        mul_valid_out = 1'b0;
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL hazard_stall_wait got=%0d exp=0 bad cycles", bad); end
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL hazard_stall_fix got=%b exp=1", stall); end
        step();
        checks++;
        if (stall !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL hazard_mfhi got=%b/%b/%h exp=0/1/ffffffff", stall, rd_valid, rd_data);
        end
        op = MFLO;
        #1;
        checks++;
        if (rd_data !== 32'hFFFFFFFA) begin failures++; $display("FAIL hazard_mflo got=%h exp=fffffffa", rd_data); end
        op_valid = 1'b0; op = NONE;
    endtask

    task automatic test_mtlo();
        op_valid = 1'b1; op = MTLO; rs_data = 32'h1234;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL mtlo_stall got=%b exp=0", stall); end
        step();
        op_valid = 1'b0; op = NONE;
        checks++;
        if (lo !== 32'h1234 || hi !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL mtlo_write got=%h_%h exp=ffffffff_00001234", hi, lo);
        end
    endtask

    task automatic test_stale();
        issue(MULTU, 32'd9, 32'd10);
        mul_valid_out = 1'b1; mul_r = 64'hDEAD;
        step(); step(); step();
        mul_valid_out = 1'b0; mul_r = 64'd0;
        checks++;
        if (busy !== 1'b1 || lo !== 32'h1234) begin
            failures++; $display("FAIL stale_ignored got=%b/%h exp=1/00001234", busy, lo);
        end
        step();
        mul_valid_out = 1'b1; mul_r = 64'd90;
        step();
        mul_valid_out = 1'b0;
        step();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd90 || busy !== 1'b0) begin
            failures++; $display("FAIL stale_result got=%h_%h/%b exp=00000000_0000005a/0", hi, lo, busy);
        end
    endtask

    task automatic test_timeout();
        int errs, at;
        errs = 0; at = 0;
        issue(MULT, 32'd4, 32'd5);
        for (int i = 1; i <= 45; i++) begin
            step();
            if (err) begin errs++; at = i; end
        end
        checks++;
        if (errs !== 1 || at !== 41) begin failures++; $display("FAIL timeout_err got=%0d@%0d exp=1@41", errs, at); end
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd90) begin
            failures++; $display("FAIL timeout_state got=%b/%h_%h exp=0/00000000_0000005a", busy, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        issue(MULT, 32'd7, 32'd8);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
            failures++; $display("FAIL midreset_state got=%b/%h exp=0/0", busy, {hi, lo});
        end
        mul_valid_out = 1'b1; mul_r = 64'd123;
        step();
        mul_valid_out = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || {hi, lo} !== 64'd0 || mul_valid_in !== 1'b0) begin
            failures++; $display("FAIL midreset_late got=%b/%h/%b exp=0/0/0", busy, {hi, lo}, mul_valid_in);
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_boundaries();
        test_hazard();
        test_mtlo();
        test_stale();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
